// File: rtl/io_port_bank.sv
// Memory-mapped bank of NUM_PORTS input/output ports: synchronised inputs, output readback,
// per-port change flags with clear-on-read, and a maskable irq. Define IO_PORT_STROBE_EN for out_strobe.
module io_port_bank #(
  parameter int                DATA_W      = 8,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_PORTS   = 16,
  parameter logic [ADDR_W-1:0] OUT_BASE    = 8'hE0,
  parameter logic [ADDR_W-1:0] IN_BASE     = 8'hF0,
  parameter logic [ADDR_W-1:0] CTRL_BASE   = 8'hDE,
  parameter int                SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        write,
  input  logic                        rd,
  output logic [DATA_W-1:0]           data_out,
  output logic                        rd_valid,
  input  logic [NUM_PORTS*DATA_W-1:0] port_in,
  output logic [NUM_PORTS*DATA_W-1:0] port_out,
  output logic [NUM_PORTS-1:0]        chg,
`ifdef IO_PORT_STROBE_EN
  output logic [NUM_PORTS-1:0]        out_strobe,
`endif
  output logic                        irq
);

  localparam int MASK_BYTES = (NUM_PORTS + DATA_W - 1) / DATA_W;
  localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CIDX_W     = (MASK_BYTES > 1) ? $clog2(MASK_BYTES) : 1;
  localparam int PRIME_MAX  = SYNC_STAGES + 1;
  localparam int PRIME_W    = $clog2(PRIME_MAX + 1);
  localparam logic [ADDR_W-1:0] NP_A = ADDR_W'(NUM_PORTS);
  localparam logic [ADDR_W-1:0] MB_A = ADDR_W'(MASK_BYTES);

  function automatic bit win_overlap(input int a, input int la, input int b, input int lb);
    return (a < b + lb) && (b < a + la);
  endfunction

  if (win_overlap(int'(OUT_BASE), NUM_PORTS, int'(IN_BASE), NUM_PORTS) ||
      win_overlap(int'(OUT_BASE), NUM_PORTS, int'(CTRL_BASE), MASK_BYTES) ||
      win_overlap(int'(IN_BASE), NUM_PORTS, int'(CTRL_BASE), MASK_BYTES)) begin : g_err_overlap
    $error("io_port_bank: OUT/IN/CTRL address windows overlap");
  end
  if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_err_ports
    $error("io_port_bank: NUM_PORTS must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("io_port_bank: SYNC_STAGES must be at least 2");
  end

  // Window decode: wrap-around subtraction makes addresses below the base land out of range
  logic [ADDR_W-1:0] w_out_off, w_in_off, w_ctrl_off;
  logic              w_out_hit, w_in_hit, w_ctrl_hit;
  logic [IDX_W-1:0]  w_out_idx, w_in_idx;
  logic [CIDX_W-1:0] w_ctrl_idx;

  assign w_out_off  = address - OUT_BASE;
  assign w_in_off   = address - IN_BASE;
  assign w_ctrl_off = address - CTRL_BASE;
  assign w_out_hit  = (w_out_off < NP_A);
  assign w_in_hit   = (w_in_off < NP_A);
  assign w_ctrl_hit = (w_ctrl_off < MB_A);
  assign w_out_idx  = w_out_off[IDX_W-1:0];
  assign w_in_idx   = w_in_off[IDX_W-1:0];
  assign w_ctrl_idx = w_ctrl_off[CIDX_W-1:0];

  logic [NUM_PORTS*DATA_W-1:0] r_sync [SYNC_STAGES];
  logic [NUM_PORTS*DATA_W-1:0] r_prev;
  logic [DATA_W-1:0]           r_out [NUM_PORTS];
  logic [DATA_W-1:0]           w_in_port [NUM_PORTS];
  logic [NUM_PORTS-1:0]        w_diff, w_set, w_clr;
  logic [NUM_PORTS-1:0]        r_mask, r_chg;
  logic [PRIME_W-1:0]          r_prime;
  logic                        w_primed;
  logic                        r_irq, r_rdv;
  logic [DATA_W-1:0]           r_dout, w_rdata;
  logic [MASK_BYTES*DATA_W-1:0] w_mask_pad;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_in_port[g] = r_sync[SYNC_STAGES-1][g*DATA_W +: DATA_W];
    assign port_out[g*DATA_W +: DATA_W] = r_out[g];
    assign w_diff[g] = |(r_sync[SYNC_STAGES-1][g*DATA_W +: DATA_W] ^ r_prev[g*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= port_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Prime: the chain and prev fill with the live inputs before any difference is trusted
  assign w_primed = (r_prime == PRIME_W'(PRIME_MAX));

  always_ff @(posedge clk) begin
    if (reset) r_prime <= '0;
    else if (!w_primed) r_prime <= r_prime + PRIME_W'(1);
  end

  assign w_set = w_primed ? w_diff : '0;
  assign w_clr = (rd && w_in_hit) ? (NUM_PORTS'(1) << w_in_idx) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chg <= '0;
      r_irq <= 1'b0;
    end else begin
      r_chg <= (r_chg & ~w_clr) | w_set;
      r_irq <= |(r_chg & r_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) r_out[i] <= '0;
    end else if (write && w_out_hit) begin
      r_out[w_out_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= '0;
    end else if (write && w_ctrl_hit) begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (i / DATA_W == int'(w_ctrl_idx)) r_mask[i] <= data_in[i % DATA_W];
    end
  end

  // Read mux sees pre-edge state, so a same-cycle write is not yet visible
  always_comb begin
    w_mask_pad = '0;
    w_mask_pad[NUM_PORTS-1:0] = r_mask;
    w_rdata = '0;
    if (w_in_hit)        w_rdata = w_in_port[w_in_idx];
    else if (w_out_hit)  w_rdata = r_out[w_out_idx];
    else if (w_ctrl_hit) w_rdata = w_mask_pad[w_ctrl_idx*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout <= '0;
      r_rdv  <= 1'b0;
    end else begin
      r_rdv <= rd;
      if (rd) r_dout <= w_rdata;
    end
  end

`ifdef IO_PORT_STROBE_EN
  logic [NUM_PORTS-1:0] r_strobe;

  always_ff @(posedge clk) begin
    if (reset) r_strobe <= '0;
    else r_strobe <= (write && w_out_hit) ? (NUM_PORTS'(1) << w_out_idx) : '0;
  end

  assign out_strobe = r_strobe;
`else
  // No write strobe in this build.
`endif

  assign data_out = r_dout;
  assign rd_valid = r_rdv;
  assign chg      = r_chg;
  assign irq      = r_irq;

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank; read data is checked against a scoreboard queue filled at issue time.
module tb_io_port_bank;
  localparam int DW = 8;
  localparam int NP = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        address = '0;
  logic [7:0]        data_in = '0;
  logic              write = 1'b0;
  logic              rd = 1'b0;
  logic [7:0]        data_out;
  logic              rd_valid;
  logic [NP*DW-1:0]  port_in = '0;
  logic [NP*DW-1:0]  port_out;
  logic [NP-1:0]     chg;
  logic              irq;
`ifdef IO_PORT_STROBE_EN
  logic [NP-1:0]     out_strobe;
`endif

  int total = 0;
  int bad = 0;
  logic [7:0]       exp_q[$];
  string            tag_q[$];
  logic [NP*DW-1:0] exp_pout = '0;

  always #5 clk = ~clk;

  io_port_bank dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .write(write), .rd(rd), .data_out(data_out), .rd_valid(rd_valid),
    .port_in(port_in), .port_out(port_out), .chg(chg),
`ifdef IO_PORT_STROBE_EN
    .out_strobe(out_strobe),
`endif
    .irq(irq)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    address = a;
    data_in = d;
    write = 1'b1;
    if (a >= 8'hE0 && a <= 8'hEF) exp_pout[(a - 8'hE0)*DW +: DW] = d;
    tick();
    write = 1'b0;
  endtask

  task automatic rdq(input logic [7:0] a, input logic [7:0] e, input string tag);
    address = a;
    rd = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    tick();
    rd = 1'b0;
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", rd_valid, 0);
      end else begin
        logic [7:0] e;
        string t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, data_out, e);
      end
    end
  end

  initial begin
    // Reset with a static nonzero input on port 0
    port_in[0 +: DW] = 8'hAA;
    repeat (3) tick();
    chk("rst_port_out", port_out, 0);
    chk("rst_chg", chg, 0);
    chk("rst_irq", irq, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_data_out", data_out, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("prime_chg", chg, 0);
      chk("prime_port_out", port_out, 0);
    end
    rdq(8'hF0, 8'hAA, "rd_in0");
    tick();
    chk("rd_valid_once", rd_valid, 0);
    chk("data_out_hold", data_out, 8'hAA);

    // Output write / readback / unmapped address
    wr(8'hE3, 8'h5A);
    chk("wr_e3", port_out, exp_pout);
    rdq(8'hE3, 8'h5A, "rd_e3");
    wr(8'hD0, 8'hFF);
    chk("wr_d0_no_effect", port_out, exp_pout);
    rdq(8'hD0, 8'h00, "rd_unmapped");
    address = 8'hE3; data_in = 8'h77; write = 1'b1; rd = 1'b1;
    exp_q.push_back(8'h5A); tag_q.push_back("rw_out_old");
    exp_pout[3*DW +: DW] = 8'h77;
    tick();
    write = 1'b0; rd = 1'b0;
    chk("wr_e3_77", port_out, exp_pout);
    rdq(8'hE3, 8'h77, "rd_e3_77");

    // Sync latency
    port_in[7*DW +: DW] = 8'h22;
    repeat (6) tick();
    chk("chg7_first", chg[7], 1);
    rdq(8'hF7, 8'h22, "rd_f7_22");
    chk("chg7_cleared_a", chg[7], 0);
    port_in[7*DW +: DW] = 8'h33;
    tick();
    rdq(8'hF7, 8'h22, "sync_n2_old");
    rdq(8'hF7, 8'h33, "sync_n3_new");
    tick();
    chk("chg7_n4", chg[7], 1);

    // Clear-on-read, then set wins over a same-cycle clear
    rdq(8'hF7, 8'h33, "clr_rd");
    chk("chg7_cleared_b", chg[7], 0);
    port_in[7*DW +: DW] = 8'h44;
    tick();
    tick();
    rdq(8'hF7, 8'h44, "setwins_rd");
    chk("chg7_set_wins", chg[7], 1);
    tick();
    chk("chg7_set_wins_hold", chg[7], 1);

    // IRQ masking
    rdq(8'hF7, 8'h44, "pre_irq_clr");
    chk("chg7_cleared_c", chg[7], 0);
    wr(8'hDE, 8'h80);
    tick();
    chk("irq_idle", irq, 0);
    rdq(8'hDE, 8'h80, "rd_mask0");
    port_in[7*DW +: DW] = 8'h45;
    repeat (3) tick();
    chk("chg7_toggle", chg[7], 1);
    chk("irq_lags_chg", irq, 0);
    tick();
    chk("irq_set", irq, 1);
    rdq(8'hF7, 8'h45, "irq_clr_rd");
    tick();
    chk("irq_drop_on_clear", irq, 0);
    port_in[2*DW +: DW] = 8'h11;
    repeat (5) tick();
    chk("chg2_set", chg[2], 1);
    chk("irq_port2_masked", irq, 0);
    port_in[7*DW +: DW] = 8'h46;
    repeat (5) tick();
    chk("irq_again", irq, 1);
    address = 8'hDE; data_in = 8'h00; write = 1'b1; rd = 1'b1;
    exp_q.push_back(8'h80); tag_q.push_back("rw_mask_old");
    tick();
    write = 1'b0; rd = 1'b0;
    tick();
    chk("irq_mask_off", irq, 0);
    rdq(8'hDE, 8'h00, "rd_mask0_zero");
    wr(8'hDF, 8'hFF);
    rdq(8'hDF, 8'hFF, "rd_mask1");
    tick();
    chk("irq_high_mask_only", irq, 0);
    wr(8'hDF, 8'h00);

    // Back-to-back writes to port 15
    address = 8'hEF; data_in = 8'h01; write = 1'b1;
    exp_pout[15*DW +: DW] = 8'h01;
    tick();
`ifdef IO_PORT_STROBE_EN
    chk("strobe_first", out_strobe, 16'h8000);
`endif
    tick();
    write = 1'b0;
`ifdef IO_PORT_STROBE_EN
    chk("strobe_second", out_strobe, 16'h8000);
`endif
    tick();
`ifdef IO_PORT_STROBE_EN
    chk("strobe_off", out_strobe, 0);
`endif
    chk("wr_ef", port_out, exp_pout);

    // Reset during an access
    address = 8'hE5; data_in = 8'hFF; write = 1'b1; rd = 1'b1; reset = 1'b1;
    tick();
    write = 1'b0; rd = 1'b0; reset = 1'b0;
    exp_pout = '0;
    chk("midrst_port_out", port_out, exp_pout);
    chk("midrst_chg", chg, 0);
    chk("midrst_irq", irq, 0);
    chk("midrst_rd_valid", rd_valid, 0);
    chk("midrst_data_out", data_out, 0);
    repeat (10) tick();
    chk("postrst_chg", chg, 0);
    chk("postrst_port_out", port_out, exp_pout);
    rdq(8'hF2, 8'h11, "postrst_in2");
    rdq(8'hF7, 8'h46, "postrst_in7");
    rdq(8'hDE, 8'h00, "postrst_mask0");

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
